// File: rtl/uart_pkg.sv
// Types, constants and helpers shared by the UART transmit and receive paths.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_FETCH,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OVERSAMPLE_DEF = 16;

  // Parity over the configured word length only; bits above it are ignored.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sp);
    logic x;
    x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(wls) + 5) x = x ^ data[i];
    end
    if (sp) return ~eps;
    return eps ? x : ~x;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts out
// start / data (LSB first) / optional parity / stop bits on txd.
//
// state  | meaning
// IDLE   | line at mark; pop the FIFO when it is not empty
// FETCH  | one cycle; capture byte and frame format or fall back to IDLE
// START  | start bit (space)
// DATA   | data bits, LSB first, 5..8 of them
// PARITY | parity bit, only when enabled
// STOP   | stop bit(s): 1, 1.5 or 2 bit periods
`timescale 1ns/1ps
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_rd_valid,
  input  logic             fifo_empty,
  input  logic [1:0]       lcr_wls,
  input  logic             lcr_stb,
  input  logic             lcr_pen,
  input  logic             lcr_eps,
  input  logic             lcr_sp,
  input  logic             lcr_brk,
  output logic             txd,
  output logic             thre,
  output logic             temt,
  output logic             tx_active
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] LAST_1   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] LAST_1P5 = TW'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_2   = TW'(2 * OVERSAMPLE - 1);

  tx_state_t     state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    wls_q;
  logic          stb_q, pen_q, par_q;
  logic          load_cfg;
  logic [TW-1:0] bit_last;
  logic          bit_done;
  logic          txd_bit;

  // Only the stop period differs in length; every other bit is one baud period.
  always_comb begin
    bit_last = LAST_1;
    if (state_q == TX_STOP && stb_q) bit_last = (wls_q == WLS_5) ? LAST_1P5 : LAST_2;
  end

  assign tx_active = (state_q == TX_START) || (state_q == TX_DATA) ||
                     (state_q == TX_PARITY) || (state_q == TX_STOP);
  assign bit_done  = tx_active && baud_tick && (tick_cnt_q == bit_last);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    load_cfg   = 1'b0;
    fifo_rd_en = 1'b0;

    if (tx_active && baud_tick) tick_cnt_d = tick_cnt_q + TW'(1);

    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty && !rst) begin
          fifo_rd_en = 1'b1;
          state_d    = TX_FETCH;
        end
      end
      TX_FETCH: begin
        if (fifo_rd_valid) begin
          load_cfg   = 1'b1;
          shift_d    = fifo_rd_data[7:0];
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          state_d    = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == (3'd4 + {1'b0, wls_q})) begin
            bit_cnt_d = '0;
            state_d   = pen_q ? TX_PARITY : TX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      TX_PARITY: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          state_d    = TX_STOP;
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          tick_cnt_d = '0;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      wls_q      <= '0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      // Frame format is frozen at fetch so LCR writes mid-frame wait for the next byte.
      if (load_cfg) begin
        wls_q <= lcr_wls;
        stb_q <= lcr_stb;
        pen_q <= lcr_pen;
        par_q <= parity_bit(fifo_rd_data[7:0], lcr_wls, lcr_eps, lcr_sp);
      end
    end
  end

  always_comb begin
    txd_bit = 1'b1;
    case (state_q)
      TX_START:  txd_bit = 1'b0;
      TX_DATA:   txd_bit = shift_q[0];
      TX_PARITY: txd_bit = par_q;
      default:   txd_bit = 1'b1;
    endcase
  end

  // Break overrides the line directly; the FSM keeps consuming bytes underneath.
  assign txd  = txd_bit & ~lcr_brk;
  assign thre = fifo_empty && (state_q != TX_FETCH);
  assign temt = thre && (state_q == TX_IDLE);

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Transmit serializer for the 16550 UART. It pops bytes from the TX fifo_lite read port and shifts them out on txd as asynchronous frames: start bit, 5-8 data bits LSB first, optional parity, then 1/1.5/2 stop bits. Bit timing comes from the 16x baud tick supplied by the baud generator. Frame format comes from the LCR fields.

Parameters:
WIDTH, 8, FIFO data width; only bits [7:0] are used.
OVERSAMPLE, 16, baud_tick pulses per bit period.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
baud_tick  in  1  one-cycle pulse at OVERSAMPLE x baud rate
fifo_rd_en  out  1  pop request to the TX FIFO
fifo_rd_data  in  WIDTH  FIFO read data; valid while fifo_rd_valid=1
fifo_rd_valid  in  1  asserted the cycle after an accepted fifo_rd_en
fifo_empty  in  1  TX FIFO empty
lcr_wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
lcr_stb  in  1  0=1 stop bit; 1=2 stop bits (1.5 when wls=00)
lcr_pen  in  1  parity enable
lcr_eps  in  1  even parity select
lcr_sp  in  1  stick parity
lcr_brk  in  1  break control
txd  out  1  serial output; idle high
thre  out  1  TX holding empty: fifo_empty and state != FETCH
temt  out  1  transmitter empty: thre and state == IDLE
tx_active  out  1  high in START, DATA, PARITY and STOP

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: txd=1, fifo_rd_en=0, tx_active=0, state=IDLE, all counters 0. Reset takes priority over everything, including mid-frame; txd=1 on the cycle after rst is sampled.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - txd=1.
  - If fifo_empty=0, assert fifo_rd_en for exactly one cycle and go to FETCH.
- FETCH (exactly one cycle):
  - If fifo_rd_valid=1, capture the shift register from fifo_rd_data and latch wls/stb/pen/eps/sp. Go to START.
  - If fifo_rd_valid=0, return to IDLE with no pop.
- LCR changes mid-frame do not affect the current frame. lcr_brk is the exception.
- Bit timing:
  - tick_cnt counts baud_tick pulses and is cleared on entry to each bit state.
  - A bit ends on the baud_tick that brings tick_cnt to OVERSAMPLE-1.
  - STOP length: 16 ticks for 1 stop, 24 ticks for 1.5, 32 ticks for 2.
- START: txd=0 from the first cycle in the state.
- DATA:
  - txd = shift[0], then shift right.
  - bit_cnt runs 0..(wls+4), then go to PARITY if pen=1, otherwise STOP.
- PARITY: bit value, computed from the data bits of the configured width only:
  - sp=0, eps=1: XOR of the data bits (total ones even).
  - sp=0, eps=0: inverse of that XOR.
  - sp=1: ~eps.
- STOP: txd=1. Then go to IDLE.
- Back-to-back frames: two clk cycles of mark (IDLE, FETCH) between frames. No tick alignment wait.
- Break: while lcr_brk=1, txd is forced to 0. The FSM keeps running, so FIFO data is consumed and lost (16550 behaviour).
- fifo_rd_en is never asserted outside IDLE. At most one pop per frame.

Decomposition:
- uart_pkg (shared with the RX side):
  - tx_state_t enum
  - WLS_5/6/7/8 constants
  - OVERSAMPLE default
  - function parity_bit(data, wls, eps, sp)
- No sub-module: the FSM, tick counter and shifter stay in one module.
- fifo_lite is instantiated beside this block in the UART top, not inside it.

Test Plan:
(All scenarios tie baud_tick=1, so one bit lasts 16 clk.)
- 8N1, FIFO holds 0x55 -> one fifo_rd_en pulse; txd = 0,1,0,1,0,1,0,1,0,1, each held 16 cycles; temt=1 when the frame ends.
- 7E1, byte 0x83 -> data bits 1,1,0,0,0,0,0; parity 0; one stop bit; bit 7 ignored. Repeat with eps=0 -> parity 1. Repeat with sp=1, eps=1 -> parity 0.
- 5-bit, stb=1, byte 0x1F -> five 1 data bits; stop held 24 cycles. Then wls=11, stb=1 -> stop held 32 cycles.
- Three bytes 0xA1, 0x00, 0xFF written back-to-back -> three frames in order; exactly 2 mark cycles between frames; thre=1 only after the third pop; FIFO empty at the end.
- lcr_brk=1 mid-frame -> txd=0 immediately and the frame continues internally. Release break in IDLE -> txd=1.
- rst asserted during DATA of 0x3C -> next cycle txd=1, tx_active=0, state IDLE. After release, the next FIFO byte transmits correctly.
